// File: rtl/pin_entry_ctrl.sv
// rtl/pin_entry_ctrl.sv - PIN entry sequencer: digit stepping, pass/fail, unlock window, lockout
// Optional inter-digit timeout enabled by defining PIN_TIMEOUT_EN.
module pin_entry_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int TMR_W          = 16,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter,
  input  logic       digit_ok,
  input  logic       cancel,
  output logic [1:0] digit_idx,
  output logic       unlocked,
  output logic       locked,
  output logic       pin_fail,
  output logic [1:0] fail_cnt
);
  typedef enum logic [1:0] {ENTRY, UNLOCK, LOCKED} state_t;

  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       MAX_F       = 3'(MAX_FAILS);

  // Reject configurations the counters cannot represent.
  generate
    if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_bad_fails
      $error("pin_entry_ctrl: MAX_FAILS must be 1..3");
    end
    if (LOCK_CYCLES < 1 || UNLOCK_CYCLES < 1 ||
        LOCK_CYCLES > (1 << TMR_W) || UNLOCK_CYCLES > (1 << TMR_W)) begin : g_bad_tmr
      $error("pin_entry_ctrl: LOCK_CYCLES/UNLOCK_CYCLES must fit in TMR_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("pin_entry_ctrl: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  state_t           state;
  logic             bad;
  logic [TMR_W-1:0] timer;
  logic [2:0]       fail_inc;
  logic             lock_now;

  assign fail_inc = {1'b0, fail_cnt} + 3'd1;
  assign lock_now = (fail_inc == MAX_F);

`ifdef PIN_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle;
  logic              idle_run;
  logic              idle_expire;

  assign idle_run    = (state == ENTRY) && !cancel && !enter && ((digit_idx != 2'd0) || bad);
  assign idle_expire = idle_run && (idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    idle <= '0;
    else if (idle_run && !idle_expire) idle <= idle + 1'b1;
    else                           idle <= '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ENTRY;
      digit_idx <= 2'd0;
      bad       <= 1'b0;
      timer     <= '0;
      fail_cnt  <= 2'd0;
      unlocked  <= 1'b0;
      locked    <= 1'b0;
      pin_fail  <= 1'b0;
    end else begin
      pin_fail <= 1'b0;
      case (state)
        ENTRY: begin
          if (cancel) begin
            digit_idx <= 2'd0;
            bad       <= 1'b0;
          end else if (enter) begin
            if (digit_idx != 2'd3) begin
              // Mismatches are only remembered; they surface after the last digit.
              digit_idx <= digit_idx + 2'd1;
              bad       <= bad | ~digit_ok;
            end else begin
              digit_idx <= 2'd0;
              bad       <= 1'b0;
              if (!bad && digit_ok) begin
                state    <= UNLOCK;
                timer    <= UNLOCK_LOAD;
                unlocked <= 1'b1;
                fail_cnt <= 2'd0;
              end else begin
                pin_fail <= 1'b1;
                fail_cnt <= fail_inc[1:0];
                if (lock_now) begin
                  state  <= LOCKED;
                  timer  <= LOCK_LOAD;
                  locked <= 1'b1;
                end
              end
            end
          end
`ifdef PIN_TIMEOUT_EN
          else if (idle_expire) begin
            digit_idx <= 2'd0;
            bad       <= 1'b0;
            pin_fail  <= 1'b1;
            fail_cnt  <= fail_inc[1:0];
            if (lock_now) begin
              state  <= LOCKED;
              timer  <= LOCK_LOAD;
              locked <= 1'b1;
            end
          end
`endif
        end
        UNLOCK: begin
          digit_idx <= 2'd0;
          if (cancel || timer == '0) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOCKED: begin
          digit_idx <= 2'd0;
          if (timer == '0) begin
            state    <= ENTRY;
            locked   <= 1'b0;
            fail_cnt <= 2'd0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state    <= ENTRY;
          unlocked <= 1'b0;
          locked   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb/tb_pin_entry_ctrl.sv - directed self-checking bench for pin_entry_ctrl (PIN 1-3-9-2)
module tb_pin_entry_ctrl;
  localparam int MAX_FAILS      = 3;
  localparam int UNLOCK_CYCLES  = 10;
  localparam int LOCK_CYCLES    = 20;
  localparam int TIMEOUT_CYCLES = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enter = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] key = 4'd0;
  logic       digit_ok;
  logic [1:0] digit_idx;
  logic [1:0] fail_cnt;
  logic       unlocked;
  logic       locked;
  logic       pin_fail;

  int errors = 0;
  int checks = 0;
  int cnt;
  logic idx_moved;

  always #5 clk = ~clk;

  function automatic logic [3:0] pin_at(input logic [1:0] i);
    case (i)
      2'd0:    return 4'd1;
      2'd1:    return 4'd3;
      2'd2:    return 4'd9;
      default: return 4'd2;
    endcase
  endfunction

  // Checker model: combinational from digit_idx and enter.
  assign digit_ok = enter && (key == pin_at(digit_idx));

  pin_entry_ctrl #(
    .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .TMR_W(16), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .digit_ok(digit_ok), .cancel(cancel),
    .digit_idx(digit_idx), .unlocked(unlocked), .locked(locked),
    .pin_fail(pin_fail), .fail_cnt(fail_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic press(input logic [3:0] k);
    key   = k;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic attempt(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_digit_idx", digit_idx, 0);
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pin_fail", pin_fail, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct PIN
    press(4'd1); chk("ok_idx1", digit_idx, 1);
    press(4'd3); chk("ok_idx2", digit_idx, 2);
    press(4'd9); chk("ok_idx3", digit_idx, 3);
    chk("ok_not_yet_unlocked", unlocked, 0);
    press(4'd2); chk("ok_idx0", digit_idx, 0);
    chk("ok_unlocked", unlocked, 1);
    chk("ok_fail_cnt", fail_cnt, 0);
    cnt = 0;
    for (int i = 0; i < 40 && unlocked; i++) begin cnt++; @(negedge clk); end
    chk("ok_unlock_len", cnt, UNLOCK_CYCLES);

    // Wrong 2nd digit
    press(4'd1); press(4'd5);
    chk("bad2_idx2", digit_idx, 2);
    chk("bad2_no_early_fail", pin_fail, 0);
    press(4'd9); chk("bad2_idx3", digit_idx, 3);
    press(4'd2);
    chk("bad2_pin_fail", pin_fail, 1);
    chk("bad2_fail_cnt", fail_cnt, 1);
    chk("bad2_unlocked", unlocked, 0);
    @(negedge clk);
    chk("bad2_pulse_once", pin_fail, 0);

    // Lockout
    attempt(4'd0, 4'd3, 4'd9, 4'd2);
    chk("lk_fail_cnt2", fail_cnt, 2);
    chk("lk_not_locked", locked, 0);
    attempt(4'd1, 4'd3, 4'd9, 4'd7);
    chk("lk_locked", locked, 1);
    chk("lk_pin_fail", pin_fail, 1);
    chk("lk_fail_cnt3", fail_cnt, 3);
    cnt = 0;
    idx_moved = 1'b0;
    for (int i = 0; i < 60 && locked; i++) begin
      cnt++;
      if (digit_idx != 2'd0) idx_moved = 1'b1;
      key   = 4'd1;
      enter = (i % 3 == 1);
      cancel = (i == 7);
      @(negedge clk);
    end
    enter = 1'b0;
    cancel = 1'b0;
    chk("lk_len", cnt, LOCK_CYCLES);
    chk("lk_idx_held", idx_moved, 0);
    chk("lk_fail_cnt_clear", fail_cnt, 0);
    attempt(4'd1, 4'd3, 4'd9, 4'd2);
    chk("lk_then_unlock", unlocked, 1);

    // Cancel during UNLOCK
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_unlock", unlocked, 0);

    // Cancel in ENTRY, wins over enter
    attempt(4'd2, 4'd3, 4'd9, 4'd2);
    chk("cx_fail_cnt1", fail_cnt, 1);
    press(4'd1); press(4'd8);
    chk("cx_idx2", digit_idx, 2);
    key = 4'd9; enter = 1'b1; cancel = 1'b1;
    @(negedge clk);
    enter = 1'b0; cancel = 1'b0;
    chk("cx_idx0", digit_idx, 0);
    chk("cx_fail_cnt", fail_cnt, 1);
    chk("cx_no_fail", pin_fail, 0);
    attempt(4'd1, 4'd3, 4'd9, 4'd2);
    chk("cx_bad_cleared", unlocked, 1);
    chk("cx_success_clear", fail_cnt, 0);
    for (int i = 0; i < 40 && unlocked; i++) @(negedge clk);
    chk("cx_unlock_expire", unlocked, 0);

    // Async reset mid-lockout
    attempt(4'd0, 4'd0, 4'd0, 4'd0);
    attempt(4'd0, 4'd0, 4'd0, 4'd0);
    press(4'd1);
    chk("rl_idx1", digit_idx, 1);
    press(4'd3); press(4'd9); press(4'd0);
    chk("rl_locked", locked, 1);
    repeat (4) @(negedge clk);
    chk("rl_still_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rl_locked0", locked, 0);
    chk("rl_fail_cnt0", fail_cnt, 0);
    chk("rl_idx0", digit_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle partial entry
    press(4'd1);
    chk("to_idx1", digit_idx, 1);
`ifdef PIN_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    chk("to_before_idx", digit_idx, 1);
    chk("to_before_fail", pin_fail, 0);
    @(negedge clk);
    chk("to_idx0", digit_idx, 0);
    chk("to_pin_fail", pin_fail, 1);
    chk("to_fail_cnt", fail_cnt, 1);
`else
    repeat (100) @(negedge clk);
    chk("noto_idx1", digit_idx, 1);
    chk("noto_no_fail", fail_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
